// File: rtl/bkram_pkg.sv
// Shared types for the backup-RAM sync controller: FSM states, operation modes
// and the SD sector size.
package bkram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REQ,
        XFER
    } state_t;

    typedef enum logic [1:0] {
        LOAD,
        SAVE_ALL,
        SAVE_DIRTY
    } mode_t;

    localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/bkram_dirty_map.sv
// Per-sector dirty bitmap. Flush has top priority; otherwise a set and a clear
// hitting the same bit in one cycle leave the bit set.
module bkram_dirty_map
    import bkram_pkg::*;
#(
    parameter int SECTORS = 64,
    localparam int SW = $clog2(SECTORS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          set_en,
    input  logic [SW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [SW-1:0] clr_idx,
    input  logic [SW-1:0] idx,
    output logic          dirty_at,
    output logic          any
);

    logic [SECTORS-1:0] bits_q;
    logic [SECTORS-1:0] bits_d;

    always_comb begin
        bits_d = bits_q;
        if (flush) begin
            bits_d = '0;
        end else begin
            if (clr_en) bits_d[clr_idx] = 1'b0;
            if (set_en) bits_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bits_q <= '0;
        else        bits_q <= bits_d;
    end

    assign dirty_at = bits_q[idx];
    assign any      = |bits_q;

endmodule

// File: rtl/bkram_sync.sv
// Backup-RAM synchronisation controller: walks the NVRAM sector by sector and
// issues SD block reads (load) or writes (save-all / save-dirty) to the HPS.
module bkram_sync
    import bkram_pkg::*;
#(
    parameter int SECTORS = 64,
    parameter int SW = $clog2(SECTORS)
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    input  logic          ena,
    input  logic          nv_we,
    input  logic [SW+8:0] nv_a,
    input  logic          mount_load,
    input  logic          img_nonempty,
    input  logic          load_req,
    input  logic          save_req,
    input  logic          save_all,
    input  logic          autosave,
    input  logic          osd_open,
    output logic [31:0]   sd_lba,
    output logic          sd_rd,
    output logic          sd_wr,
    input  logic          sd_ack,
    output logic          busy,
    output logic          loading,
    output logic          pending
);

    localparam int OFS_W = $clog2(SECTOR_BYTES);
    localparam logic [SW-1:0] LAST = SW'(SECTORS - 1);

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d, trig_mode;
    logic [SW-1:0] idx_q, idx_d, lba_q, lba_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic          busy_q, busy_d, loading_q, loading_d;
    logic          old_ack_q, old_load_q, old_save_q;
    logic          ack_rise, ack_fall, load_rise, save_rise;
    logic          trig, load_start, clr_en, dirty_at, any_dirty;
    logic          unused_ofs;

    assign ack_rise   = sd_ack & ~old_ack_q;
    assign ack_fall   = ~sd_ack & old_ack_q;
    assign load_rise  = load_req & ~old_load_q;
    assign save_rise  = save_req & ~old_save_q;
    assign unused_ofs = ^nv_a[OFS_W-1:0];

    always_comb begin
        trig      = 1'b1;
        trig_mode = LOAD;
        if (mount_load && img_nonempty) trig_mode = LOAD;
        else if (load_rise)             trig_mode = LOAD;
        else if (save_rise)             trig_mode = save_all ? SAVE_ALL : SAVE_DIRTY;
        else if (autosave && osd_open && any_dirty) trig_mode = SAVE_DIRTY;
        else                            trig = 1'b0;
    end

    assign load_start = (state_q == IDLE) && ena && trig && (trig_mode == LOAD);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && trig) begin
                    mode_d  = trig_mode;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // ena low stops the walk before another request goes out
                if (!ena) begin
                    state_d = IDLE;
                end else if (mode_q != SAVE_DIRTY || dirty_at) begin
                    lba_d   = idx_q;
                    rd_d    = (mode_q == LOAD);
                    wr_d    = (mode_q != LOAD);
                    state_d = REQ;
                end else if (idx_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    clr_en = (mode_q != LOAD);
                    if (idx_q == LAST || !ena) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        lba_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        loading_d = busy_d && (mode_d == LOAD);
    end

    always_ff @(posedge clk_sys) begin
        old_ack_q  <= sd_ack;
        old_load_q <= load_req;
        old_save_q <= save_req;
        if (!RESET_n) begin
            state_q    <= IDLE;
            mode_q     <= SAVE_DIRTY;
            idx_q      <= '0;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            loading_q  <= 1'b0;
            old_ack_q  <= 1'b0;
            old_load_q <= 1'b0;
            old_save_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            lba_q     <= lba_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            loading_q <= loading_d;
        end
    end

    bkram_dirty_map #(
        .SECTORS (SECTORS)
    ) u_dirty (
        .clk      (clk_sys),
        .rst_n    (RESET_n),
        .flush    (!ena || load_start),
        .set_en   (nv_we),
        .set_idx  (nv_a[SW+OFS_W-1:OFS_W]),
        .clr_en   (clr_en),
        .clr_idx  (idx_q),
        .idx      (idx_q),
        .dirty_at (dirty_at),
        .any      (any_dirty)
    );

    assign sd_lba  = {{(32-SW){1'b0}}, lba_q};
    assign sd_rd   = rd_q;
    assign sd_wr   = wr_q;
    assign busy    = busy_q;
    assign loading = loading_q;
    assign pending = any_dirty;

endmodule

// File: tb/tb_bkram_sync.sv
// Directed bench for bkram_sync with a request scoreboard and a hand-driven
// HPS acknowledge.
module tb_bkram_sync;

    localparam int SECTORS = 64;
    localparam int SW = $clog2(SECTORS);

    logic          clk_sys = 1'b0;
    logic          RESET_n = 1'b0;
    logic          ena = 1'b1;
    logic          nv_we = 1'b0;
    logic [SW+8:0] nv_a = '0;
    logic          mount_load = 1'b0;
    logic          img_nonempty = 1'b1;
    logic          load_req = 1'b0;
    logic          save_req = 1'b0;
    logic          save_all = 1'b0;
    logic          autosave = 1'b0;
    logic          osd_open = 1'b0;
    logic [31:0]   sd_lba;
    logic          sd_rd;
    logic          sd_wr;
    logic          sd_ack = 1'b0;
    logic          busy;
    logic          loading;
    logic          pending;

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic req_prev = 1'b0;
    logic mon_req;
    exp_t mon_e;

    bkram_sync #(.SECTORS(SECTORS)) dut (
        .clk_sys      (clk_sys),
        .RESET_n      (RESET_n),
        .ena          (ena),
        .nv_we        (nv_we),
        .nv_a         (nv_a),
        .mount_load   (mount_load),
        .img_nonempty (img_nonempty),
        .load_req     (load_req),
        .save_req     (save_req),
        .save_all     (save_all),
        .autosave     (autosave),
        .osd_open     (osd_open),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .busy         (busy),
        .loading      (loading),
        .pending      (pending)
    );

    initial forever #5 clk_sys = ~clk_sys;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each new request is matched against the next scoreboard entry.
    always @(negedge clk_sys) begin
        mon_req = sd_rd | sd_wr;
        if (mon_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(mon_req), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("req_type", 32'(sd_wr), 32'(mon_e.wr));
                chk("req_lba", sd_lba, mon_e.lba);
                if (!mon_e.wr) chk("loading_on_rd", 32'(loading), 32'd1);
            end
        end
        req_prev <= mon_req;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        step();
        step();
        RESET_n = 1'b1;
        step();
    endtask

    task automatic mark(input int sec);
        nv_a = '0;
        nv_a[SW+8:9] = SW'(sec);
        nv_we = 1'b1;
        step();
        nv_we = 1'b0;
    endtask

    task automatic push(input logic wr, input int lba);
        exp_t e;
        e.wr  = wr;
        e.lba = 32'(lba);
        exp_q.push_back(e);
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        step();
        save_req = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(sd_rd || sd_wr) && n < 300) begin
            step();
            n++;
        end
        chk("req_timeout", 32'(sd_rd | sd_wr), 32'd1);
    endtask

    task automatic ack_rise();
        sd_ack = 1'b1;
        step();
        chk("req_drop", 32'(sd_rd | sd_wr), 32'd0);
    endtask

    task automatic xfer(input int hold);
        wait_req();
        ack_rise();
        repeat (hold) step();
        sd_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        // reset state
        step();
        step();
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        RESET_n = 1'b1;
        step();

        // mount-time load of all sectors
        for (int i = 0; i < SECTORS; i++) push(1'b0, i);
        mount_load = 1'b1;
        step();
        mount_load = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_loading", 32'(loading), 32'd1);
        for (int i = 0; i < SECTORS; i++) xfer(2);
        chk("load_busy_last", 32'(busy), 32'd1);
        step();
        chk("load_busy_fall", 32'(busy), 32'd0);
        chk("load_loading_fall", 32'(loading), 32'd0);
        chk("load_q_empty", 32'(exp_q.size()), 32'd0);

        // dirty-only save of sectors 1 and 63
        do_reset();
        chk("pending_clean", 32'(pending), 32'd0);
        mark(1);
        chk("pending_lag", 32'(pending), 32'd1);
        mark(63);
        push(1'b1, 1);
        push(1'b1, 63);
        save_all = 1'b0;
        pulse_save();
        xfer(2);
        xfer(2);
        step();
        chk("dsave_busy", 32'(busy), 32'd0);
        chk("dsave_pending", 32'(pending), 32'd0);
        chk("dsave_q_empty", 32'(exp_q.size()), 32'd0);

        // write to sector 5 while it is being saved, including the ack-fall cycle
        mark(5);
        push(1'b1, 5);
        pulse_save();
        wait_req();
        ack_rise();
        nv_a = '0;
        nv_a[SW+8:9] = SW'(5);
        nv_we = 1'b1;
        step();
        sd_ack = 1'b0;
        step();
        nv_we = 1'b0;
        wait_idle();
        chk("setwins_pending", 32'(pending), 32'd1);
        chk("setwins_q_empty", 32'(exp_q.size()), 32'd0);

        // autosave fires on the first dirty sector; edges during it are dropped
        do_reset();
        autosave = 1'b1;
        osd_open = 1'b1;
        repeat (5) step();
        chk("auto_idle_clean", 32'(busy), 32'd0);
        push(1'b1, 7);
        mark(7);
        chk("auto_not_yet", 32'(busy), 32'd0);
        step();
        chk("auto_start", 32'(busy), 32'd1);
        load_req = 1'b1;
        save_req = 1'b1;
        save_all = 1'b1;
        step();
        xfer(1);
        wait_idle();
        chk("auto_pending", 32'(pending), 32'd0);
        repeat (5) step();
        chk("auto_no_retrig", 32'(busy), 32'd0);
        chk("auto_q_empty", 32'(exp_q.size()), 32'd0);
        load_req = 1'b0;
        save_req = 1'b0;
        autosave = 1'b0;
        osd_open = 1'b0;
        step();

        // save-all with a clean bitmap writes every sector
        save_all = 1'b1;
        for (int i = 0; i < SECTORS; i++) push(1'b1, i);
        pulse_save();
        save_all = 1'b0;
        for (int i = 0; i < SECTORS; i++) xfer(1);
        step();
        chk("saveall_busy", 32'(busy), 32'd0);
        chk("saveall_q_empty", 32'(exp_q.size()), 32'd0);

        // dirty-only save with nothing dirty
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        n = 1;
        chk("empty_busy_rise", 32'(busy), 32'd1);
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("empty_idle_after_trig", 32'(n), 32'(SECTORS + 1));
        chk("empty_no_req", 32'(sd_wr | sd_rd), 32'd0);

        // reset during the request for sector 10; a late ack is ignored
        mark(10);
        push(1'b1, 10);
        pulse_save();
        wait_req();
        chk("rst_mid_lba", sd_lba, 32'd10);
        RESET_n = 1'b0;
        step();
        chk("rst_mid_wr", 32'(sd_wr), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pending", 32'(pending), 32'd0);
        RESET_n = 1'b1;
        sd_ack = 1'b1;
        step();
        step();
        sd_ack = 1'b0;
        step();
        step();
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_wr", 32'(sd_wr), 32'd0);

        // ena drop while sector 3 transfers
        mark(3);
        mark(4);
        push(1'b1, 3);
        pulse_save();
        wait_req();
        ack_rise();
        ena = 1'b0;
        step();
        sd_ack = 1'b0;
        step();
        chk("ena_drop_busy", 32'(busy), 32'd0);
        chk("ena_drop_pending", 32'(pending), 32'd0);
        repeat (5) step();
        ena = 1'b1;
        repeat (3) step();
        chk("ena_drop_idle", 32'(busy), 32'd0);
        chk("ena_drop_q_empty", 32'(exp_q.size()), 32'd0);
        chk("ena_drop_pending_after", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
